led_update_scheduler: RTL and testbench

//  Sequences colour-detection events from the line-follower's colour sensor onto the
//  3-slot RGB LED controller. Each accepted detection is assigned the next LED slot
//  (1,2,3), buffered in a small FIFO and replayed as one timed command
//  {LED_num, red/green/blue}. Sits between colour detection and the LED controller.

---
 rtl/led_update_scheduler.sv | 145 ++++++++++++++
 tb/tb_led_update_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_update_scheduler.sv
// led_update_scheduler: assigns LED slots to colour detections, buffers them and
// replays each as a timed one-hot command with a blank gap to the RGB LED controller.
module led_update_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int WRAP        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       det_valid,
    input  logic [1:0] det_color,
    output logic       det_ready,
    input  logic       clear,
    output logic [1:0] led_num,
    output logic       red_out,
    output logic       green_out,
    output logic       blue_out,
    output logic [1:0] slot_count,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop, wrap_block;
    logic [3:0]    head;
    logic [1:0]    next_slot;
    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    led_next;
    logic [2:0]    rgb, rgb_next;

    function automatic logic [2:0] color_lines(input logic [1:0] c);
        case (c)
            2'b01:   return 3'b100;
            2'b10:   return 3'b010;
            2'b11:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign wrap_block = (WRAP == 0) && (slot_count == 2'd3);
    assign det_ready  = !rst && !full && !clear && !wrap_block;
    assign push       = det_valid && det_ready && (det_color != 2'b00);
    assign busy       = !empty || (state != IDLE);
    assign {red_out, green_out, blue_out} = rgb;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        led_next   = led_num;
        rgb_next   = rgb;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                led_next = '0;
                rgb_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    led_next   = head[3:2];
                    rgb_next   = color_lines(head[1:0]);
                    cnt_next   = HOLD_LOAD;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    led_next   = '0;
                    rgb_next   = '0;
                    state_next = GAP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            GAP: begin
                led_next   = '0;
                rgb_next   = '0;
                state_next = IDLE;
            end
            default: begin
                led_next   = '0;
                rgb_next   = '0;
                state_next = IDLE;
            end
        endcase
        // A flush aborts the in-flight command and must not consume the head entry.
        if (clear) begin
            state_next = IDLE;
            cnt_next   = '0;
            led_next   = '0;
            rgb_next   = '0;
            pop        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            led_num <= '0;
            rgb     <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            led_num <= led_next;
            rgb     <= rgb_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            next_slot  <= 2'd1;
            slot_count <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                next_slot <= (next_slot == 2'd3) ? 2'd1 : next_slot + 2'd1;
                if (slot_count != 2'd3)
                    slot_count <= slot_count + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {next_slot, det_color};
    end

endmodule

// File: tb/tb_led_update_scheduler.sv
// Bench for led_update_scheduler: a timeline model predicts each command's start edge
// from acceptance time and the previous start, then outputs are compared every cycle.
module tb_led_update_scheduler;
    localparam int HOLD  = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, det_valid, clear, det_ready, red_out, green_out, blue_out, busy;
    logic [1:0] det_color, led_num, slot_count;
    logic       det_valid0, clear0, det_ready0, red0, green0, blue0, busy0;
    logic [1:0] det_color0, led_num0, slot_count0;

    led_update_scheduler #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .WRAP(1)) dut (
        .clk(clk), .rst(rst), .det_valid(det_valid), .det_color(det_color),
        .det_ready(det_ready), .clear(clear), .led_num(led_num), .red_out(red_out),
        .green_out(green_out), .blue_out(blue_out), .slot_count(slot_count), .busy(busy));

    led_update_scheduler #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .det_valid(det_valid0), .det_color(det_color0),
        .det_ready(det_ready0), .clear(clear0), .led_num(led_num0), .red_out(red0),
        .green_out(green0), .blue_out(blue0), .slot_count(slot_count0), .busy(busy0));

    always #5 clk = ~clk;

    typedef struct {
        int         start;
        logic [1:0] slot;
        logic [1:0] color;
    } cmd_t;

    cmd_t       cmds[$];
    int         edge_no = 0;
    int         last_start = -1000;
    logic [1:0] m_next = 2'd1;
    logic [1:0] m_count = 2'd0;
    logic       m_ready_pre, dut_ready_pre;
    int         checks = 0;
    int         failures = 0;
    int         starts0 = 0;
    logic [1:0] prev0 = 2'd0;

    always @(negedge clk) begin
        if (led_num0 != 2'd0 && prev0 == 2'd0) starts0++;
        prev0 = led_num0;
    end

    function automatic int occ_after(int e);
        int n = 0;
        foreach (cmds[i]) if (cmds[i].start > e) n++;
        return n;
    endfunction

    // {led_num, red, green, blue, slot_count, busy} expected after the latest edge
    function automatic logic [7:0] model_out();
        logic [1:0] led = 2'd0;
        logic [2:0] rgb = 3'd0;
        logic       b   = (occ_after(edge_no) > 0);
        foreach (cmds[i]) begin
            if (cmds[i].start <= edge_no && edge_no <= cmds[i].start + HOLD - 1) begin
                led = cmds[i].slot;
                rgb = 3'b001 << (3 - int'(cmds[i].color));
            end
            if (cmds[i].start <= edge_no && edge_no <= cmds[i].start + HOLD) b = 1'b1;
        end
        return {led, rgb, m_count, b};
    endfunction

    task automatic tick();
        int   e;
        cmd_t c;
        @(negedge clk);
        m_ready_pre   = !rst && !clear && (occ_after(edge_no) < DEPTH);
        dut_ready_pre = det_ready;
        e = edge_no + 1;
        if (rst || clear) begin
            cmds.delete();
            last_start = -1000;
            m_next     = 2'd1;
            m_count    = 2'd0;
        end else if (det_valid && m_ready_pre && det_color != 2'b00) begin
            c.start = (e + 1 > last_start + HOLD + 2) ? e + 1 : last_start + HOLD + 2;
            c.slot  = m_next;
            c.color = det_color;
            cmds.push_back(c);
            last_start = c.start;
            m_next = (m_next == 2'd3) ? 2'd1 : m_next + 2'd1;
            if (m_count != 2'd3) m_count = m_count + 2'd1;
        end
        @(posedge clk);
        #1;
        edge_no = e;
        while (cmds.size() > 0 && cmds[0].start + HOLD < e) void'(cmds.pop_front());
    endtask

    task automatic test_reset();
        rst = 1'b1; det_valid = 1'b0; det_color = 2'b00; clear = 1'b0;
        det_valid0 = 1'b0; det_color0 = 2'b00; clear0 = 1'b0;
        tick(); tick();
        checks++;
        if ({dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy} !== 9'd0) begin
            failures++;
            $display("FAIL reset got=%b exp=%b", {dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy}, 9'd0);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_red();
        det_valid = 1'b1; det_color = 2'b01;
        tick();
        det_valid = 1'b0; det_color = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if ({dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy} !== {m_ready_pre, model_out()}) begin
                failures++;
                $display("FAIL single_red cyc=%0d got=%b exp=%b", i, {dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy}, {m_ready_pre, model_out()});
            end
            if (i == 4) begin
                checks++;
                if ({led_num, red_out} !== 3'b011) begin
                    failures++;
                    $display("FAIL single_red_hold got=%b exp=011", {led_num, red_out});
                end
            end
            if (i == 6) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL single_red_busy got=%b exp=0", busy);
                end
            end
        end
    endtask

    task automatic test_three_colors();
        clear = 1'b1; tick(); clear = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            det_valid = 1'b1; det_color = 2'(k);
            tick();
        end
        det_valid = 1'b0; det_color = 2'b00;
        repeat (20) begin
            tick();
            checks++;
            if ({dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy} !== {m_ready_pre, model_out()}) begin
                failures++;
                $display("FAIL three_colors cyc=%0d got=%b exp=%b", edge_no, {dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy}, {m_ready_pre, model_out()});
            end
        end
        checks++;
        if (slot_count !== 2'd3) begin
            failures++;
            $display("FAIL three_colors_count got=%0d exp=3", slot_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] issued[$];
        logic [1:0] prev = 2'd0;
        logic       saw_block = 1'b0;
        logic       acc;
        int         waited;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int k = 0; k < 6; k++) begin
            det_valid = 1'b1; det_color = 2'($urandom_range(1, 3));
            acc = 1'b0; waited = 0;
            while (!acc && waited < 40) begin
                tick();
                waited++;
                acc = dut_ready_pre;
                if (!dut_ready_pre) saw_block = 1'b1;
                checks++;
                if ({dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy} !== {m_ready_pre, model_out()}) begin
                    failures++;
                    $display("FAIL back_to_back cyc=%0d got=%b exp=%b", edge_no, {dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy}, {m_ready_pre, model_out()});
                end
                if (led_num != 2'd0 && prev == 2'd0) issued.push_back(led_num);
                prev = led_num;
            end
            checks++;
            if (!acc) begin
                failures++;
                $display("FAIL back_to_back_timeout event=%0d got=not_accepted exp=accepted", k);
            end
        end
        det_valid = 1'b0; det_color = 2'b00;
        repeat (60) begin
            tick();
            checks++;
            if ({dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy} !== {m_ready_pre, model_out()}) begin
                failures++;
                $display("FAIL back_to_back_drain cyc=%0d got=%b exp=%b", edge_no, {dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy}, {m_ready_pre, model_out()});
            end
            if (led_num != 2'd0 && prev == 2'd0) issued.push_back(led_num);
            prev = led_num;
        end
        checks++;
        if (issued.size() != 6) begin
            failures++;
            $display("FAIL back_to_back_count got=%0d exp=6", issued.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (issued[i] !== 2'((i % 3) + 1)) begin
                    failures++;
                    $display("FAIL back_to_back_slot idx=%0d got=%0d exp=%0d", i, issued[i], (i % 3) + 1);
                end
            end
        end
        checks++;
        if (!saw_block) begin
            failures++;
            $display("FAIL back_to_back_full got=ready_always exp=ready_dropped");
        end
    endtask

    task automatic test_wrap0();
        clear0 = 1'b1; tick(); clear0 = 1'b0;
        starts0 = 0;
        for (int k = 1; k <= 3; k++) begin
            det_valid0 = 1'b1; det_color0 = 2'(k);
            #1;
            checks++;
            if (det_ready0 !== 1'b1) begin
                failures++;
                $display("FAIL wrap0_accept k=%0d got=%b exp=1", k, det_ready0);
            end
            tick();
        end
        det_color0 = 2'b01;
        #1;
        checks++;
        if (det_ready0 !== 1'b0) begin
            failures++;
            $display("FAIL wrap0_block got=%b exp=0", det_ready0);
        end
        repeat (30) tick();
        checks++;
        if (starts0 != 3 || slot_count0 !== 2'd3) begin
            failures++;
            $display("FAIL wrap0_issued got=%0d/%0d exp=3/3", starts0, slot_count0);
        end
        det_valid0 = 1'b0;
        clear0 = 1'b1;
        #1;
        checks++;
        if (det_ready0 !== 1'b0) begin
            failures++;
            $display("FAIL wrap0_clear_ready got=%b exp=0", det_ready0);
        end
        tick();
        clear0 = 1'b0;
        #1;
        checks++;
        if (det_ready0 !== 1'b1) begin
            failures++;
            $display("FAIL wrap0_after_clear got=%b exp=1", det_ready0);
        end
        det_valid0 = 1'b1; det_color0 = 2'b10;
        tick();
        det_valid0 = 1'b0; det_color0 = 2'b00;
        tick();
        checks++;
        if ({led_num0, red0, green0, blue0} !== 5'b01010) begin
            failures++;
            $display("FAIL wrap0_slot1 got=%b exp=01010", {led_num0, red0, green0, blue0});
        end
    endtask

    task automatic test_none_color();
        clear = 1'b1; tick(); clear = 1'b0;
        det_valid = 1'b1; det_color = 2'b00;
        repeat (5) begin
            tick();
            checks++;
            if ({dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy} !== {m_ready_pre, model_out()}) begin
                failures++;
                $display("FAIL none_color cyc=%0d got=%b exp=%b", edge_no, {dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy}, {m_ready_pre, model_out()});
            end
        end
        checks++;
        if ({led_num, red_out, green_out, blue_out, slot_count, busy} !== 8'd0) begin
            failures++;
            $display("FAIL none_color_idle got=%b exp=0", {led_num, red_out, green_out, blue_out, slot_count, busy});
        end
        det_color = 2'b01;
        tick();
        det_valid = 1'b0; det_color = 2'b00;
        tick();
        checks++;
        if ({led_num, red_out} !== 3'b011) begin
            failures++;
            $display("FAIL none_color_slot got=%b exp=011", {led_num, red_out});
        end
        repeat (8) tick();
    endtask

    task automatic test_abort(input logic use_rst);
        clear = 1'b1; tick(); clear = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            det_valid = 1'b1; det_color = 2'(k);
            tick();
        end
        det_valid = 1'b1; det_color = 2'b11;
        if (use_rst) rst = 1'b1; else clear = 1'b1;
        tick();
        rst = 1'b0; clear = 1'b0; det_valid = 1'b0; det_color = 2'b00;
        checks++;
        if ({led_num, red_out, green_out, blue_out, slot_count, busy} !== 8'd0) begin
            failures++;
            $display("FAIL abort rst=%b got=%b exp=0", use_rst, {led_num, red_out, green_out, blue_out, slot_count, busy});
        end
        repeat (15) begin
            tick();
            checks++;
            if ({dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy} !== {m_ready_pre, model_out()}) begin
                failures++;
                $display("FAIL abort_after rst=%b cyc=%0d got=%b exp=%b", use_rst, edge_no, {dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy}, {m_ready_pre, model_out()});
            end
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            det_valid = 1'($urandom_range(0, 1));
            det_color = 2'($urandom_range(0, 3));
            clear     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            tick();
            checks++;
            if ({dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy} !== {m_ready_pre, model_out()}) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", edge_no, {dut_ready_pre, led_num, red_out, green_out, blue_out, slot_count, busy}, {m_ready_pre, model_out()});
            end
            checks++;
            if (int'(red_out) + int'(green_out) + int'(blue_out) > 1 || ((red_out || green_out || blue_out) && led_num == 2'd0)) begin
                failures++;
                $display("FAIL one_hot cyc=%0d got=%b exp=onehot_with_slot", edge_no, {led_num, red_out, green_out, blue_out});
            end
        end
        rst = 1'b0; clear = 1'b0; det_valid = 1'b0; det_color = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_red();
        test_three_colors();
        test_back_to_back();
        test_wrap0();
        test_none_color();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
